cve2v_bench_monitor: RTL

- Parametrised benchmark region monitor for the CVE2 + Spatz vector system; successor to the single-region fence-delimited cycle counter.
- Observes the RVFI retirement stream and a vector-unit idle indication.
- Measures up to NumRegions marker-delimited regions, each reporting cycles and retired instructions through a valid/ready result port.
- Optionally waits for vector-unit drain before closing a region, with a bounded timeout. Sits beside the core in the tracing top; simulation and FPGA use only.

---
 rtl/cve2v_bench_monitor_if.sv | 23 ++
 rtl/cve2v_bench_monitor.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/cve2v_bench_monitor_if.sv
// Result channel of the benchmark region monitor.
// master drives a region result; slave consumes it with ready.
interface cve2v_bench_monitor_if #(
   parameter int unsigned RIdW     = 2,
   parameter int unsigned CntWidth = 32
);
   logic                valid;
   logic                ready;
   logic [RIdW-1:0]     region;
   logic [CntWidth-1:0] cycles;
   logic [CntWidth-1:0] instret;
   logic                timeout;

   modport master (
      output valid, region, cycles, instret, timeout,
      input  ready
   );

   modport slave (
      input  valid, region, cycles, instret, timeout,
      output ready
   );
endinterface

// File: rtl/cve2v_bench_monitor.sv
// Benchmark region monitor: counts cycles and retired instructions
// between marker instructions, optionally waiting for vector drain.
// Ports: clk_i/rst_ni/clear_i control; rvfi_valid_i/rvfi_insn_i
// retirement stream; vec_idle_i vector idle; busy_o, overrun_o,
// done_o status; result (master) carries each finished region.
module cve2v_bench_monitor #(
   parameter int unsigned NumRegions   = 4,
   parameter int unsigned CntWidth     = 32,
   parameter logic [31:0] MarkerInsn   = 32'h0ff0000f,
   parameter bit          WaitVector   = 1'b1,
   parameter int unsigned DrainTimeout = 1024,
   localparam int unsigned RIdW =
      (NumRegions > 1) ? $clog2(NumRegions) : 1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        clear_i,
   input  logic        rvfi_valid_i,
   input  logic [31:0] rvfi_insn_i,
   input  logic        vec_idle_i,
   output logic        busy_o,
   output logic        overrun_o,
   output logic        done_o,
   cve2v_bench_monitor_if.master result
);

   // Region count must be able to hold NumRegions itself.
   localparam int unsigned RCntW = $clog2(NumRegions + 1);
   localparam int unsigned DrnW =
      (DrainTimeout > 0) ? $clog2(DrainTimeout + 1) : 1;
   localparam int unsigned DrnLastI =
      (DrainTimeout > 0) ? DrainTimeout - 1 : 0;
   localparam logic [DrnW-1:0]  DrnLast = DrnLastI[DrnW-1:0];
   localparam logic [RCntW-1:0] RLast   = RCntW'(NumRegions);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_REPORT
   } state_e;

   state_e              state_q, state_d;
   logic [CntWidth-1:0] cyc_q, cyc_d;
   logic [CntWidth-1:0] ins_q, ins_d;
   logic [DrnW-1:0]     drn_q, drn_d;
   logic                to_q, to_d;
   logic [RCntW-1:0]    rcnt_q, rcnt_d;
   logic                done_q, done_d;
   logic                valid_q, valid_d;
   logic [RIdW-1:0]     region_q, region_d;
   logic [CntWidth-1:0] rcyc_q, rcyc_d;
   logic [CntWidth-1:0] rins_q, rins_d;
   logic                rto_q, rto_d;
   logic                ovr_q, ovr_d;

   logic mark;
   logic drn_exp;
   logic open_region;
   logic load;

   assign mark        = rvfi_valid_i && (rvfi_insn_i == MarkerInsn);
   assign drn_exp     = (DrainTimeout != 0) && (drn_q == DrnLast);
   assign open_region = mark && !done_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= S_IDLE;
         cyc_q    <= '0;
         ins_q    <= '0;
         drn_q    <= '0;
         to_q     <= 1'b0;
         rcnt_q   <= '0;
         done_q   <= 1'b0;
         valid_q  <= 1'b0;
         region_q <= '0;
         rcyc_q   <= '0;
         rins_q   <= '0;
         rto_q    <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cyc_q    <= cyc_d;
         ins_q    <= ins_d;
         drn_q    <= drn_d;
         to_q     <= to_d;
         rcnt_q   <= rcnt_d;
         done_q   <= done_d;
         valid_q  <= valid_d;
         region_q <= region_d;
         rcyc_q   <= rcyc_d;
         rins_q   <= rins_d;
         rto_q    <= rto_d;
         ovr_q    <= ovr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (open_region) state_d = S_RUN;
         end
         S_RUN: begin
            if (mark) begin
               if (!WaitVector || vec_idle_i) state_d = S_REPORT;
               else                           state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (vec_idle_i || drn_exp) state_d = S_REPORT;
         end
         S_REPORT: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
      if (clear_i) state_d = S_IDLE;
   end

   always_comb begin
      cyc_d    = cyc_q;
      ins_d    = ins_q;
      drn_d    = drn_q;
      to_d     = to_q;
      rcnt_d   = rcnt_q;
      done_d   = done_q;
      valid_d  = valid_q;
      region_d = region_q;
      rcyc_d   = rcyc_q;
      rins_d   = rins_q;
      rto_d    = rto_q;
      ovr_d    = ovr_q;
      load     = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (open_region) begin
               cyc_d = '0;
               ins_d = '0;
               to_d  = 1'b0;
            end
         end
         S_RUN: begin
            // Counters saturate instead of wrapping.
            if (!(&cyc_q)) cyc_d = cyc_q + CntWidth'(1);
            if (rvfi_valid_i && !mark && !(&ins_q)) begin
               ins_d = ins_q + CntWidth'(1);
            end
            if (mark) drn_d = '0;
         end
         S_DRAIN: begin
            if (!(&cyc_q)) cyc_d = cyc_q + CntWidth'(1);
            if (!(&drn_q)) drn_d = drn_q + DrnW'(1);
            // Idle wins over an expiring timeout in the same cycle.
            if (!vec_idle_i && drn_exp) to_d = 1'b1;
         end
         S_REPORT: load = 1'b1;
         default: ;
      endcase

      if (load) begin
         valid_d  = 1'b1;
         region_d = rcnt_q[RIdW-1:0];
         rcyc_d   = cyc_q;
         rins_d   = ins_q;
         rto_d    = to_q;
         rcnt_d   = rcnt_q + RCntW'(1);
         if (rcnt_q + RCntW'(1) == RLast) done_d = 1'b1;
         if (valid_q && !result.ready) ovr_d = 1'b1;
      end else if (valid_q && result.ready) begin
         valid_d = 1'b0;
      end

      if (clear_i) begin
         cyc_d    = '0;
         ins_d    = '0;
         drn_d    = '0;
         to_d     = 1'b0;
         rcnt_d   = '0;
         done_d   = 1'b0;
         valid_d  = 1'b0;
         region_d = '0;
         rcyc_d   = '0;
         rins_d   = '0;
         rto_d    = 1'b0;
         ovr_d    = 1'b0;
      end
   end

   assign busy_o         = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign overrun_o      = ovr_q;
   assign done_o         = done_q;
   assign result.valid   = valid_q;
   assign result.region  = region_q;
   assign result.cycles  = rcyc_q;
   assign result.instret = rins_q;
   assign result.timeout = rto_q;

endmodule
